edge_threshold: RTL and testbench
=================================

EDGE_THRESHOLD -- requirements
Module: edge_threshold

Interface
REQ-001 SHALL have parameter MAX_WIDTH, default 1000, the maximum source image width in pixels.
REQ-002 SHALL have parameter EDGE_W, default 16, the width of the signed gradient sample.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse that begins a frame; sampled in IDLE only.
REQ-006 SHALL have port width  input  16  source image width; latched on accepted start.
REQ-007 SHALL have port height  input  16  source image height; latched on accepted start.
REQ-008 SHALL have port threshold  input  8  binarisation level; latched on accepted start.
REQ-009 SHALL have port mode  input  1  output mode (0 = clamped magnitude, 1 = binary); latched on accepted start.
REQ-010 SHALL have port edge_in  input  EDGE_W  signed gradient sample from the upstream Sobel stage.
REQ-011 SHALL have port edge_valid  input  1  edge_in holds a valid sample.
REQ-012 SHALL have port edge_ready  output  1  block accepts edge_in this cycle.
REQ-013 SHALL have port pix_out  output  8  processed edge pixel.
REQ-014 SHALL have port pix_valid  output  1  pix_out, pix_x and pix_y are valid.
REQ-015 SHALL have port pix_ready  input  1  downstream accepts pix_out this cycle.
REQ-016 SHALL have port pix_x  output  16  column of pix_out within the edge frame (0..width-3).
REQ-017 SHALL have port pix_y  output  16  row of pix_out within the edge frame (0..height-3).
REQ-018 SHALL have port frame_done  output  1  one-cycle pulse after the last pixel transfer.
REQ-019 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-020 SHALL implement the states IDLE, RUN, DRAIN and DONE.
REQ-021 SHALL move IDLE->RUN on start; while not in IDLE, start SHALL be ignored.
REQ-022 SHALL move IDLE->DONE directly when started with width<3, height<3, or width>MAX_WIDTH, emitting no pixels.
REQ-023 SHALL expect exactly (width-2)*(height-2) input samples per frame, in raster order.
REQ-024 SHALL transfer on an input or output only when its valid and ready are both high.
REQ-025 SHALL hold edge_ready low in IDLE, DRAIN and DONE, and in RUN whenever the pipeline is full and pix_ready is low.
REQ-026 SHALL use a 2-stage pipeline: stage 1 = |edge_in|, with -2^(EDGE_W-1) saturating to 2^(EDGE_W-1)-1; stage 2 = clamp to 255, then apply the mode.
REQ-027 SHALL, in mode 1, output pix_out = 8'hFF when the clamped magnitude >= threshold and 8'h00 otherwise; in mode 0, pix_out SHALL equal the clamped magnitude.
REQ-028 SHALL assert pix_valid 2 cycles after an input transfer when pix_ready is held high, and SHALL sustain 1 sample per cycle.
REQ-029 SHALL hold pix_out, pix_x, pix_y and pix_valid stable while pix_valid is high and pix_ready is low, with no sample lost or duplicated.
REQ-030 SHALL advance pix_x on each output transfer; at width-3 it SHALL wrap to 0 and increment pix_y.
REQ-031 SHALL move RUN->DRAIN after the final input transfer, and DRAIN->DONE after the final output transfer.
REQ-032 SHALL pulse frame_done high for exactly one cycle in DONE, then return to IDLE.
REQ-033 SHALL, when a threshold of 0 is used in mode 1, output 8'hFF for every pixel.

Reset
REQ-034 SHALL, while rstn is low, force IDLE with pix_out=0, pix_valid=0, edge_ready=0, pix_x=0, pix_y=0, frame_done=0, busy=0, and clear the pipeline.
REQ-035 SHALL discard any in-flight frame on a mid-frame reset; the next frame SHALL restart at pix_x=0, pix_y=0.

Structure
REQ-036 SHALL place the state encoding, MAX_WIDTH and the pixel and edge width constants in the shared package edge_pkg.
REQ-037 SHALL implement the stage-1 absolute value and saturation in one sub-module, edge_mag_sat.

Verification
REQ-038 Bench SHALL drive width=5, height=4, mode=1, threshold=100, inputs {-300,50,100,99,-100,0} with pix_ready=1 -> outputs {FF,00,FF,00,FF,00}, coords (0,0)..(2,1), then one frame_done pulse.
REQ-039 Bench SHALL drive mode=0 with inputs {-32768,255,256,-1} -> outputs {FF,FF,FF,01}.
REQ-040 Bench SHALL toggle pix_ready randomly at 50% -> output sequence identical to the pix_ready=1 run, and outputs stable while stalled.
REQ-041 Bench SHALL start with width=2 -> frame_done within 2 cycles, no pix_valid.
REQ-042 Bench SHALL pulse rstn low after 3 outputs, then start a new frame -> first output coords (0,0), all outputs at reset values during reset.

Source files
------------

// File: rtl/edge_pkg.sv
// Shared constants, FSM encoding and latched-frame configuration for edge_threshold.
package edge_pkg;

  localparam int unsigned MAX_WIDTH_DEF = 1000;
  localparam int unsigned EDGE_W_DEF    = 16;
  localparam int unsigned PIX_W         = 8;
  localparam int unsigned DIM_W         = 16;
  localparam int unsigned CNT_W         = 32;
  localparam int unsigned PIX_MAX       = 255;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [DIM_W-1:0] width;
    logic [PIX_W-1:0] threshold;
    logic             mode;
  } cfg_t;

  // Mode 1 binarises against the threshold; mode 0 passes the clamped magnitude.
  function automatic logic [PIX_W-1:0] map_pix(input logic [PIX_W-1:0] clamped,
                                               input logic [PIX_W-1:0] thr,
                                               input logic             bin);
    if (!bin) return clamped;
    return (clamped >= thr) ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
  endfunction

endpackage

// File: rtl/edge_mag_sat.sv
// Pipeline stage 1: registered |edge| with the most-negative code saturated to max positive.
module edge_mag_sat
  import edge_pkg::*;
#(
  parameter int unsigned EDGE_W = EDGE_W_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              load_i,
  input  logic [EDGE_W-1:0] edge_i,
  output logic [EDGE_W-2:0] mag_o
);

  localparam int unsigned MAG_W = EDGE_W - 1;

  logic [EDGE_W-1:0] neg;
  logic [MAG_W-1:0]  mag_d;
  logic [MAG_W-1:0]  mag_q;

  always_comb begin
    neg   = ~edge_i + EDGE_W'(1);
    mag_d = edge_i[MAG_W-1:0];
    if (edge_i[EDGE_W-1]) begin
      // Only the most-negative code is still negative after negation.
      if (neg[EDGE_W-1]) mag_d = {MAG_W{1'b1}};
      else               mag_d = neg[MAG_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       mag_q <= '0;
    else if (load_i) mag_q <= mag_d;
  end

  assign mag_o = mag_q;

endmodule

// File: rtl/edge_threshold.sv
// Two-stage edge magnitude / binarisation pipeline with raster coordinates and frame FSM.
module edge_threshold
  import edge_pkg::*;
#(
  parameter int unsigned MAX_WIDTH = MAX_WIDTH_DEF,
  parameter int unsigned EDGE_W    = EDGE_W_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [DIM_W-1:0]  width,
  input  logic [DIM_W-1:0]  height,
  input  logic [PIX_W-1:0]  threshold,
  input  logic              mode,
  input  logic [EDGE_W-1:0] edge_in,
  input  logic              edge_valid,
  output logic              edge_ready,
  output logic [PIX_W-1:0]  pix_out,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [DIM_W-1:0]  pix_x,
  output logic [DIM_W-1:0]  pix_y,
  output logic              frame_done,
  output logic              busy
);

  localparam int unsigned MAG_W = EDGE_W - 1;

  state_e           state_q, state_d;
  cfg_t             cfg_q, cfg_d;
  logic [CNT_W-1:0] total_q, total_d;
  logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
  logic             frame_done_q, frame_done_d;
  logic             busy_q, busy_d;

  logic             s1_valid_q, s1_valid_d;
  logic [MAG_W-1:0] s1_mag;
  logic [PIX_W-1:0] pix_out_q, pix_out_d;
  logic             pix_valid_q, pix_valid_d;
  logic [DIM_W-1:0] pix_x_q, pix_x_d;
  logic [DIM_W-1:0] pix_y_q, pix_y_d;

  logic             edge_ready_c;
  logic             in_xfer_c;
  logic             out_xfer_c;
  logic             adv2_c;
  logic             degen_c;
  logic             accept_start_c;
  logic [PIX_W-1:0] clamp_c;

  // Handshake qualifiers: stage 2 moves when empty or drained, stage 1 when stage 2 moves.
  always_comb begin
    adv2_c         = !pix_valid_q || pix_ready;
    edge_ready_c   = (state_q == ST_RUN) && (!s1_valid_q || adv2_c);
    in_xfer_c      = edge_valid && edge_ready_c;
    out_xfer_c     = pix_valid_q && pix_ready;
    accept_start_c = (state_q == ST_IDLE) && start;
    degen_c        = (width < DIM_W'(3)) || (height < DIM_W'(3)) ||
                     (CNT_W'(width) > MAX_WIDTH);
    clamp_c        = (s1_mag > MAG_W'(PIX_MAX)) ? {PIX_W{1'b1}} : s1_mag[PIX_W-1:0];
  end

  // Frame FSM: next state, configuration latch, input accounting.
  always_comb begin
    state_d   = state_q;
    cfg_d     = cfg_q;
    total_d   = total_q;
    in_cnt_d  = in_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cfg_d.width     = width;
          cfg_d.threshold = threshold;
          cfg_d.mode      = mode;
          total_d         = CNT_W'(width - DIM_W'(2)) * CNT_W'(height - DIM_W'(2));
          in_cnt_d        = '0;
          state_d         = degen_c ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (in_xfer_c) begin
          in_cnt_d = in_cnt_q + CNT_W'(1);
          if (in_cnt_q == total_q - CNT_W'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!s1_valid_q && (out_xfer_c || !pix_valid_q)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    frame_done_d = (state_d == ST_DONE);
    busy_d       = (state_d != ST_IDLE);
  end

  // Pipeline occupancy, output pixel and raster coordinates.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    pix_valid_d = pix_valid_q;
    pix_out_d   = pix_out_q;
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;
    if (adv2_c) begin
      pix_valid_d = s1_valid_q;
      if (s1_valid_q) pix_out_d = map_pix(clamp_c, cfg_q.threshold, cfg_q.mode);
    end
    if (!s1_valid_q || adv2_c) s1_valid_d = in_xfer_c;
    if (accept_start_c) begin
      pix_x_d = '0;
      pix_y_d = '0;
    end else if (out_xfer_c) begin
      if (pix_x_q == cfg_q.width - DIM_W'(3)) begin
        pix_x_d = '0;
        pix_y_d = pix_y_q + DIM_W'(1);
      end else begin
        pix_x_d = pix_x_q + DIM_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      cfg_q        <= '0;
      total_q      <= '0;
      in_cnt_q     <= '0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      s1_valid_q   <= 1'b0;
      pix_valid_q  <= 1'b0;
      pix_out_q    <= '0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
    end else begin
      state_q      <= state_d;
      cfg_q        <= cfg_d;
      total_q      <= total_d;
      in_cnt_q     <= in_cnt_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      s1_valid_q   <= s1_valid_d;
      pix_valid_q  <= pix_valid_d;
      pix_out_q    <= pix_out_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
    end
  end

  edge_mag_sat #(
    .EDGE_W (EDGE_W)
  ) u_mag (
    .clk    (clk),
    .rstn   (rstn),
    .load_i (in_xfer_c),
    .edge_i (edge_in),
    .mag_o  (s1_mag)
  );

  assign edge_ready = edge_ready_c;
  assign pix_out    = pix_out_q;
  assign pix_valid  = pix_valid_q;
  assign pix_x      = pix_x_q;
  assign pix_y      = pix_y_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_edge_threshold.sv
// Directed vector bench for edge_threshold: frame tables, stalls, degenerate frames, mid-frame reset.
module tb_edge_threshold;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [15:0] width;
  logic [15:0] height;
  logic [7:0]  threshold;
  logic        mode;
  logic [15:0] edge_in;
  logic        edge_valid;
  logic        edge_ready;
  logic [7:0]  pix_out;
  logic        pix_valid;
  logic        pix_ready;
  logic [15:0] pix_x;
  logic [15:0] pix_y;
  logic        frame_done;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [15:0] edge_v;
    logic [7:0]  exp_pix;
    logic [15:0] exp_x;
    logic [15:0] exp_y;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  edge_threshold dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .width      (width),
    .height     (height),
    .threshold  (threshold),
    .mode       (mode),
    .edge_in    (edge_in),
    .edge_valid (edge_valid),
    .edge_ready (edge_ready),
    .pix_out    (pix_out),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .frame_done (frame_done),
    .busy       (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input int e, input logic [7:0] p, input int x, input int y);
    vec_t v;
    v.edge_v  = 16'(e);
    v.exp_pix = p;
    v.exp_x   = 16'(x);
    v.exp_y   = 16'(y);
    vecs.push_back(v);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pix_out"},    32'(pix_out),    32'h0);
    chk({tag, "_pix_valid"},  32'(pix_valid),  32'h0);
    chk({tag, "_edge_ready"}, 32'(edge_ready), 32'h0);
    chk({tag, "_pix_x"},      32'(pix_x),      32'h0);
    chk({tag, "_pix_y"},      32'(pix_y),      32'h0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'h0);
    chk({tag, "_busy"},       32'(busy),       32'h0);
  endtask

  task automatic pulse_start(input int w, input int h, input int thr, input logic md);
    @(posedge clk); #1;
    width = 16'(w); height = 16'(h); threshold = 8'(thr); mode = md; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drive_inputs(input int n);
    for (int i = 0; i < n; i++) begin
      int guard;
      guard      = 0;
      edge_in    = vecs[i].edge_v;
      edge_valid = 1'b1;
      @(negedge clk);
      while (!edge_ready && guard < 300) begin
        @(negedge clk);
        guard++;
      end
      if (!edge_ready) begin
        chk($sformatf("in_accept_timeout[%0d]", i), 32'(edge_ready), 32'h1);
        break;
      end
      @(posedge clk); #1;
    end
    edge_valid = 1'b0;
  endtask

  task automatic monitor(input int n, input logic rnd);
    int          got;
    int          cyc;
    logic        stalled;
    logic [7:0]  hp;
    logic [15:0] hx, hy;
    got = 0; cyc = 0; stalled = 1'b0; hp = '0; hx = '0; hy = '0;
    while (got < n && cyc < 400) begin
      @(posedge clk); #1;
      pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      cyc++;
      if (stalled) begin
        chk("stall_valid", 32'(pix_valid), 32'h1);
        chk("stall_pix",   32'(pix_out),   32'(hp));
        chk("stall_x",     32'(pix_x),     32'(hx));
        chk("stall_y",     32'(pix_y),     32'(hy));
      end
      if (pix_valid && pix_ready) begin
        chk($sformatf("pix[%0d]", got), 32'(pix_out), 32'(vecs[got].exp_pix));
        chk($sformatf("x[%0d]", got),   32'(pix_x),   32'(vecs[got].exp_x));
        chk($sformatf("y[%0d]", got),   32'(pix_y),   32'(vecs[got].exp_y));
        got++;
        stalled = 1'b0;
      end else if (pix_valid) begin
        stalled = 1'b1;
        hp = pix_out; hx = pix_x; hy = pix_y;
      end else begin
        stalled = 1'b0;
      end
    end
    if (got < n) chk("out_timeout", 32'(got), 32'(n));
    @(posedge clk); #1;
    pix_ready = 1'b1;
  endtask

  task automatic check_done(input string tag);
    int pulses;
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (frame_done) pulses++;
    end
    chk({tag, "_frame_done_pulses"}, 32'(pulses), 32'h1);
    chk({tag, "_busy_after"}, 32'(busy), 32'h0);
  endtask

  task automatic run_frame(input string tag, input int w, input int h, input int thr,
                           input logic md, input logic rnd);
    int n;
    n = vecs.size();
    pulse_start(w, h, thr, md);
    fork
      drive_inputs(n);
      monitor(n, rnd);
    join
    check_done(tag);
  endtask

  task automatic degenerate(input string tag, input int w, input int h);
    int saw_done;
    int saw_valid;
    saw_done = 0; saw_valid = 0;
    pulse_start(w, h, 10, 1'b1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (frame_done) saw_done++;
      if (pix_valid)  saw_valid++;
    end
    chk({tag, "_done_seen"}, 32'(saw_done), 32'h1);
    chk({tag, "_no_valid"},  32'(saw_valid), 32'h0);
    repeat (3) @(negedge clk);
  endtask

  task automatic load_binary_frame();
    vecs.delete();
    add_vec(-300, 8'hFF, 0, 0);
    add_vec(50,   8'h00, 1, 0);
    add_vec(100,  8'hFF, 2, 0);
    add_vec(99,   8'h00, 0, 1);
    add_vec(-100, 8'hFF, 1, 1);
    add_vec(0,    8'h00, 2, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; start = 1'b0; width = '0; height = '0; threshold = '0; mode = 1'b0;
    edge_in = '0; edge_valid = 1'b0; pix_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Binary mode, threshold 100, free-flowing output.
    load_binary_frame();
    run_frame("bin", 5, 4, 100, 1'b1, 1'b0);

    // Clamped magnitude mode including saturation of the most negative code.
    vecs.delete();
    add_vec(-32768, 8'hFF, 0, 0);
    add_vec(255,    8'hFF, 1, 0);
    add_vec(256,    8'hFF, 0, 1);
    add_vec(-1,     8'h01, 1, 1);
    run_frame("mag", 4, 4, 0, 1'b0, 1'b0);

    // One-column edge frame: pix_x wraps every pixel.
    vecs.delete();
    add_vec(0,     8'h00, 0, 0);
    add_vec(7,     8'h07, 0, 1);
    add_vec(-128,  8'h80, 0, 2);
    add_vec(32767, 8'hFF, 0, 3);
    run_frame("col", 3, 6, 0, 1'b0, 1'b0);

    // Threshold zero in binary mode forces every pixel high.
    vecs.delete();
    add_vec(0,  8'hFF, 0, 0);
    add_vec(-1, 8'hFF, 1, 0);
    run_frame("thr0", 4, 3, 0, 1'b1, 1'b0);

    // Same binary frame under random backpressure.
    load_binary_frame();
    run_frame("stall", 5, 4, 100, 1'b1, 1'b1);

    degenerate("w2", 2, 4);
    degenerate("h2", 5, 2);
    degenerate("wmax", 1001, 4);

    // Abort a frame after three outputs, then restart from the origin.
    load_binary_frame();
    pulse_start(5, 4, 100, 1'b1);
    fork
      drive_inputs(4);
      monitor(3, 1'b0);
    join
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    repeat (2) @(negedge clk);
    check_reset_outputs("mid_rst_hold");
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    run_frame("restart", 5, 4, 100, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
